mem_sync_arbiter: RTL and testbench
===================================

// Module: mem_sync_arbiter
// PURPOSE
//  Shares one backing-memory row-transfer port among all per-bank MEMSync row caches.
//  Each bank raises a fill or writeback request carrying its DRAM RowId and cache row (cRowId).
//  Grants one bank at a time (round-robin) and runs a fixed-length beat transfer.
//  Returns a one-cycle sync pulse to that bank, which lets its MEMSync leave Allocate.
// PARAMETERS
//  BGWIDTH     2   bank-group address bits
//  BAWIDTH     2   bank address bits; NBANKS = 2**(BGWIDTH+BAWIDTH), bank id = {bg,ba}
//  CHWIDTH     6   cache-row index bits
//  ADDRWIDTH   17  DRAM row address bits
//  XFERBEATS   4   beats per row transfer (>=1); BEATW = max(1,$clog2(XFERBEATS))
// PORTS
//  clk        in   1                  clock
//  reset      in   1                  synchronous, active-high reset
//  req        in   NBANKS             per-bank request level; held until that bank's sync
//  req_wb     in   NBANKS             1 = writeback (cache->mem), 0 = fill (mem->cache)
//  req_row    in   NBANKS*ADDRWIDTH   per-bank RowId; bank i at [i*ADDRWIDTH +: ADDRWIDTH]
//  req_crow   in   NBANKS*CHWIDTH     per-bank cRowId; bank i at [i*CHWIDTH +: CHWIDTH]
//  mem_ready  in   1                  backing memory accepts current beat
//  sync       out  NBANKS             one-cycle completion pulse to the granted bank
//  mem_valid  out  1                  beat valid on the memory port
//  mem_wb     out  1                  direction of current transfer
//  mem_row    out  ADDRWIDTH          latched RowId of granted bank
//  mem_crow   out  CHWIDTH            latched cRowId of granted bank
//  mem_beat   out  BEATW              beat index 0..XFERBEATS-1
//  grant_id   out  BGWIDTH+BAWIDTH    currently granted bank
//  busy       out  1                  high in GRANT, XFER and DONE
// BEHAVIOUR
//  Reset: state IDLE; sync, mem_valid, mem_wb, mem_row, mem_crow, mem_beat, grant_id, busy all 0.
//    RR pointer = 0. Reset mid-transfer abandons it; no sync pulse is issued.
//  FSM IDLE -> GRANT -> XFER -> DONE -> IDLE.
//  IDLE: if any req, pick the first requesting bank at or after the RR pointer (wrapping NBANKS-1 -> 0).
//    Latch id, req_wb, req_row and req_crow into grant_id, mem_wb, mem_row and mem_crow. Go to GRANT.
//  GRANT: one cycle; busy=1, mem_valid=0 (gives the bank one cycle to settle); go to XFER with mem_beat=0.
//  XFER: mem_valid=1. The beat advances only on mem_valid & mem_ready.
//    When mem_beat==XFERBEATS-1 is accepted, go to DONE. mem_ready=0 holds all outputs stable.
//  DONE: sync[grant_id]=1 for exactly this cycle; mem_valid=0; RR pointer = grant_id+1 (mod NBANKS); go to IDLE.
//  Latency: req seen in IDLE at cycle N -> sync at cycle N+XFERBEATS+3 when mem_ready is held high.
//  Bank inputs are sampled only in IDLE. Changes to req_row, req_crow or req_wb after grant are ignored.
//  A granted req that drops before DONE does not abort the transfer; sync still pulses.
//  A request arriving in GRANT, XFER or DONE waits; no requests are lost. Simultaneous requests are resolved by RR only.
//  The bank that just completed has lowest priority next round, so there is no starvation.
//    Worst-case wait = (NBANKS-1)*(XFERBEATS+3) cycles with mem_ready high.
//  sync is never asserted for a non-granted bank; at most one sync bit is high per cycle.
// CONFIGURATION
//  MEMSYNC_ARB_WBPRIO_EN defined: in IDLE, if any requesting bank has req_wb=1, RR arbitration is restricted to writeback requesters.
//    Fills are chosen only when no writeback is pending, so dirty rows are flushed before a cache row is refilled.
//  Not defined: pure round-robin; req_wb only sets mem_wb.
// TESTING
//  1 single: req[0]=1, wb=0, row=0x1ABCD, crow=5, mem_ready=1 -> mem_valid for 4 cycles (beats 0..3) from N+2,
//    mem_row=0x1ABCD, sync[0] pulses at N+7.
//  2 backpressure: as 1 with mem_ready=0 for 3 cycles during beat 2 -> beat 2 and mem_row are held; sync at N+10.
//  3 RR fairness: req on banks 0, 5, 15 at once -> grants in order 0, 5, 15; bank 0 re-requests immediately -> served after 15.
//  4 wrap: pointer=15, req on banks 15 and 2 -> 15 is granted first, then 2.
//  5 reset mid-XFER at beat 1 -> the next cycle shows all outputs 0 and no sync; the re-issued request restarts at beat 0.
//  6 WBPRIO: fill on bank 1 and writeback on bank 9 with pointer 0 -> macro on: 9 then 1; macro off: 1 then 9.

Source files
------------

// File: rtl/mem_sync_arbiter.sv
// Round-robin arbiter sharing one backing-memory row-transfer port among the per-bank MEMSync
// row caches. Define MEMSYNC_ARB_WBPRIO_EN to serve pending writebacks ahead of fills.
module mem_sync_arbiter #(
   parameter int unsigned BGWIDTH   = 2,
   parameter int unsigned BAWIDTH   = 2,
   parameter int unsigned CHWIDTH   = 6,
   parameter int unsigned ADDRWIDTH = 17,
   parameter int unsigned XFERBEATS = 4,
   localparam int unsigned IDW      = BGWIDTH + BAWIDTH,
   localparam int unsigned NBANKS   = 2 ** IDW,
   localparam int unsigned BEATW    = (XFERBEATS > 1) ? $clog2(XFERBEATS) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NBANKS-1:0]             req,
   input  logic [NBANKS-1:0]             req_wb,
   input  logic [NBANKS*ADDRWIDTH-1:0]   req_row,
   input  logic [NBANKS*CHWIDTH-1:0]     req_crow,
   input  logic                          mem_ready,
   output logic [NBANKS-1:0]             sync,
   output logic                          mem_valid,
   output logic                          mem_wb,
   output logic [ADDRWIDTH-1:0]          mem_row,
   output logic [CHWIDTH-1:0]            mem_crow,
   output logic [BEATW-1:0]              mem_beat,
   output logic [IDW-1:0]                grant_id,
   output logic                          busy
);

   localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(XFERBEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      XFER  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state, state_n;
   logic [IDW-1:0]        rr_ptr, rr_ptr_n;
   logic [NBANKS-1:0]     sync_n;
   logic                  mem_valid_n;
   logic                  mem_wb_n;
   logic [ADDRWIDTH-1:0]  mem_row_n;
   logic [CHWIDTH-1:0]    mem_crow_n;
   logic [BEATW-1:0]      mem_beat_n;
   logic [IDW-1:0]        grant_id_n;
   logic                  busy_n;

   logic [NBANKS-1:0]     cand;
   logic [IDW-1:0]        pick_id;
   logic                  pick_vld;
   logic [IDW-1:0]        scan_idx;

   // Eligible requesters; the bank receiving sync this cycle still shows its old req level
   always_comb begin
      cand = req & ~sync;
`ifdef MEMSYNC_ARB_WBPRIO_EN
      if ((cand & req_wb) != '0) begin
         cand = cand & req_wb;
      end
`endif
   end

   // First eligible bank at or after the round-robin pointer, wrapping modulo NBANKS
   always_comb begin
      pick_id  = '0;
      pick_vld = 1'b0;
      scan_idx = '0;
      for (int unsigned i = 0; i < NBANKS; i++) begin
         scan_idx = rr_ptr + IDW'(i);
         if (!pick_vld && cand[scan_idx]) begin
            pick_id  = scan_idx;
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_n     = state;
      rr_ptr_n    = rr_ptr;
      sync_n      = '0;
      mem_valid_n = 1'b0;
      mem_wb_n    = mem_wb;
      mem_row_n   = mem_row;
      mem_crow_n  = mem_crow;
      mem_beat_n  = mem_beat;
      grant_id_n  = grant_id;
      busy_n      = busy;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_n    = GRANT;
               grant_id_n = pick_id;
               mem_wb_n   = req_wb[pick_id];
               mem_row_n  = req_row[32'(pick_id) * ADDRWIDTH +: ADDRWIDTH];
               mem_crow_n = req_crow[32'(pick_id) * CHWIDTH +: CHWIDTH];
               mem_beat_n = '0;
               busy_n     = 1'b1;
            end
         end
         GRANT: begin
            state_n     = XFER;
            mem_valid_n = 1'b1;
         end
         XFER: begin
            mem_valid_n = 1'b1;
            if (mem_valid && mem_ready) begin
               if (mem_beat == LAST_BEAT) begin
                  state_n     = DONE;
                  mem_valid_n = 1'b0;
               end else begin
                  mem_beat_n = mem_beat + 1'b1;
               end
            end
         end
         DONE: begin
            state_n          = IDLE;
            sync_n[grant_id] = 1'b1;
            rr_ptr_n         = grant_id + 1'b1;
            busy_n           = 1'b0;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         sync      <= '0;
         mem_valid <= 1'b0;
         mem_wb    <= 1'b0;
         mem_row   <= '0;
         mem_crow  <= '0;
         mem_beat  <= '0;
         grant_id  <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         rr_ptr    <= rr_ptr_n;
         sync      <= sync_n;
         mem_valid <= mem_valid_n;
         mem_wb    <= mem_wb_n;
         mem_row   <= mem_row_n;
         mem_crow  <= mem_crow_n;
         mem_beat  <= mem_beat_n;
         grant_id  <= grant_id_n;
         busy      <= busy_n;
      end
   end

endmodule

// File: tb/tb_mem_sync_arbiter.sv
// Self-checking bench for mem_sync_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_sync_arbiter;

   localparam int NB  = 16;
   localparam int IDW = 4;
   localparam int AW  = 17;
   localparam int CW  = 6;
   localparam int XB  = 4;
   localparam int BW  = 2;
   localparam int OW  = NB + 1 + 1 + AW + CW + BW + IDW + 1;
`ifdef MEMSYNC_ARB_WBPRIO_EN
   localparam bit WBPRIO = 1'b1;
`else
   localparam bit WBPRIO = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [NB-1:0]     req, req_wb;
   logic [NB*AW-1:0]  req_row;
   logic [NB*CW-1:0]  req_crow;
   logic              mem_ready;
   logic [NB-1:0]     sync;
   logic              mem_valid, mem_wb, busy;
   logic [AW-1:0]     mem_row;
   logic [CW-1:0]     mem_crow;
   logic [BW-1:0]     mem_beat;
   logic [IDW-1:0]    grant_id;

   int checks = 0;
   int failures = 0;

   mem_sync_arbiter dut (
      .clk(clk), .reset(reset), .req(req), .req_wb(req_wb), .req_row(req_row),
      .req_crow(req_crow), .mem_ready(mem_ready), .sync(sync), .mem_valid(mem_valid),
      .mem_wb(mem_wb), .mem_row(mem_row), .mem_crow(mem_crow), .mem_beat(mem_beat),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: one transfer record (bank, latched fields, cycles since grant, beats accepted)
   int            m_pick;
   int            m_bank = 0;
   int            m_t = 0;
   int            m_acc = 0;
   int            m_ptr = 0;
   int            m_sync = -1;
   bit            m_busy = 1'b0;
   logic          m_wb;
   logic [AW-1:0] m_row;
   logic [CW-1:0] m_crow;

   function automatic int rr_pick(input logic [NB-1:0] r, input logic [NB-1:0] w, input int ptr);
      logic [NB-1:0] c;
      int best, bestd;
      c = r;
      best = -1;
      bestd = NB;
      if (WBPRIO && ((r & w) != '0)) c = r & w;
      for (int b = 0; b < NB; b++) begin
         if (c[b] && ((b - ptr + NB) % NB) < bestd) begin
            best  = b;
            bestd = (b - ptr + NB) % NB;
         end
      end
      return best;
   endfunction

   always_comb m_pick = rr_pick(req, req_wb, m_ptr);

   always @(posedge clk) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_ptr  <= 0;
         m_sync <= -1;
         m_t    <= 0;
         m_acc  <= 0;
      end else begin
         m_sync <= -1;
         if (!m_busy) begin
            if (m_pick >= 0) begin
               m_busy <= 1'b1;
               m_bank <= m_pick;
               m_wb   <= req_wb[m_pick];
               m_row  <= req_row[m_pick*AW +: AW];
               m_crow <= req_crow[m_pick*CW +: CW];
               m_t    <= 0;
               m_acc  <= 0;
            end
         end else if (m_acc == XB) begin
            m_busy <= 1'b0;
            m_sync <= m_bank;
            m_ptr  <= (m_bank + 1) % NB;
         end else begin
            if (m_t >= 1 && mem_ready) m_acc <= m_acc + 1;
            m_t <= m_t + 1;
         end
      end
   end

   logic [NB-1:0] exp_sync;
   logic          exp_valid;
   logic [OW-1:0] expv, mask;
   wire  [OW-1:0] obs = {sync, mem_valid, mem_wb, mem_row, mem_crow, mem_beat, grant_id, busy};

   always_comb begin
      exp_sync = '0;
      if (m_sync >= 0) exp_sync[m_sync] = 1'b1;
      exp_valid = m_busy && (m_t >= 1) && (m_acc < XB);
      expv = {exp_sync, exp_valid, m_wb, m_row, m_crow, BW'(m_acc), IDW'(m_bank), m_busy};
      mask = {{NB{1'b1}}, 1'b1, {(1 + AW + CW){m_busy}}, {BW{exp_valid}}, {IDW{m_busy}}, 1'b1};
   end

   // Advance one clock; a bank lowers its request as soon as it sees its sync pulse
   task automatic tick();
      @(posedge clk);
      #1;
      req = req & ~exp_sync;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      req = '0;
      req_wb = '0;
      mem_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      if (obs !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got %h want 0", obs);
      end
      checks++;
      if ((obs & mask) !== (expv & mask)) begin
         failures++;
         $display("FAIL reset_model: got %h want %h", obs & mask, expv & mask);
      end
      checks++;
      reset = 1'b0;
   endtask

   task automatic test_single();
      int sync_at = -1;
      int first_v = -1;
      int nvalid = 0;
      logic [AW-1:0] row_seen = '0;
      req_wb[0] = 1'b0;
      req_row[0 +: AW] = 17'h1ABCD;
      req_crow[0 +: CW] = 6'd5;
      mem_ready = 1'b1;
      req[0] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if ((obs & mask) !== (expv & mask)) begin
            failures++;
            $display("FAIL single_cycle%0d: got %h want %h", k, obs & mask, expv & mask);
         end
         checks++;
         if (mem_valid) begin
            nvalid++;
            if (first_v < 0) begin
               first_v = k;
               row_seen = mem_row;
            end
         end
         if (sync[0] && sync_at < 0) sync_at = k;
      end
      if (sync_at !== 7) begin
         failures++;
         $display("FAIL single_sync_latency: got %0d want 7", sync_at);
      end
      checks++;
      if (first_v !== 2 || nvalid !== 4) begin
         failures++;
         $display("FAIL single_valid_window: first %0d count %0d want first 2 count 4", first_v, nvalid);
      end
      checks++;
      if (row_seen !== 17'h1ABCD) begin
         failures++;
         $display("FAIL single_row: got %h want 1abcd", row_seen);
      end
      checks++;
   endtask

   task automatic test_backpressure();
      int sync_at = -1;
      req[0] = 1'b1;
      mem_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if ((obs & mask) !== (expv & mask)) begin
            failures++;
            $display("FAIL bp_cycle%0d: got %h want %h", k, obs & mask, expv & mask);
         end
         checks++;
         if (k == 6) begin
            if (!mem_valid || mem_beat !== 2'd2 || mem_row !== 17'h1ABCD) begin
               failures++;
               $display("FAIL bp_hold: valid %b beat %0d row %h want 1 2 1abcd", mem_valid, mem_beat, mem_row);
            end
            checks++;
         end
         if (sync[0] && sync_at < 0) sync_at = k;
         if (k == 4) mem_ready = 1'b0;
         if (k == 7) mem_ready = 1'b1;
      end
      if (sync_at !== 10) begin
         failures++;
         $display("FAIL bp_sync_latency: got %0d want 10", sync_at);
      end
      checks++;
   endtask

   task automatic test_rr();
      int seq[$];
      int exp_seq[4] = '{0, 5, 15, 0};
      bit prev_busy = 1'b0;
      bit re0 = 1'b0;
      bit did0 = 1'b0;
      reset_dut();
      req[0] = 1'b1;
      req[5] = 1'b1;
      req[15] = 1'b1;
      for (int k = 0; k < 80 && seq.size() < 4; k++) begin
         tick();
         if ((obs & mask) !== (expv & mask)) begin
            failures++;
            $display("FAIL rr_cycle%0d: got %h want %h", k, obs & mask, expv & mask);
         end
         checks++;
         if (re0) begin
            req[0] = 1'b1;
            re0 = 1'b0;
         end
         if (busy && !prev_busy) seq.push_back(int'(grant_id));
         prev_busy = busy;
         if (sync[0] && !did0) begin
            did0 = 1'b1;
            re0 = 1'b1;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (i >= seq.size() || seq[i] != exp_seq[i]) begin
            failures++;
            $display("FAIL rr_order[%0d]: got %0d want %0d", i, (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
         end
         checks++;
      end
   endtask

   task automatic test_wrap();
      int seq[$];
      int exp_seq[3] = '{14, 15, 2};
      bit prev_busy = 1'b0;
      reset_dut();
      req[14] = 1'b1;
      for (int k = 0; k < 80 && seq.size() < 3; k++) begin
         tick();
         if ((obs & mask) !== (expv & mask)) begin
            failures++;
            $display("FAIL wrap_cycle%0d: got %h want %h", k, obs & mask, expv & mask);
         end
         checks++;
         if (busy && !prev_busy) seq.push_back(int'(grant_id));
         prev_busy = busy;
         if (sync[14]) begin
            req[15] = 1'b1;
            req[2] = 1'b1;
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (i >= seq.size() || seq[i] != exp_seq[i]) begin
            failures++;
            $display("FAIL wrap_order[%0d]: got %0d want %0d", i, (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
         end
         checks++;
      end
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      reset_dut();
      req[3] = 1'b1;
      for (int k = 0; k < 20 && !found; k++) begin
         tick();
         if ((obs & mask) !== (expv & mask)) begin
            failures++;
            $display("FAIL rmid_pre%0d: got %h want %h", k, obs & mask, expv & mask);
         end
         checks++;
         if (mem_valid && mem_beat == 2'd1) found = 1'b1;
      end
      if (!found) begin
         failures++;
         $display("FAIL rmid_reach_beat1: got none want beat 1");
      end
      checks++;
      reset = 1'b1;
      tick();
      if (obs !== '0) begin
         failures++;
         $display("FAIL rmid_reset_outputs: got %h want 0", obs);
      end
      checks++;
      reset = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         tick();
         if ((obs & mask) !== (expv & mask)) begin
            failures++;
            $display("FAIL rmid_post%0d: got %h want %h", k, obs & mask, expv & mask);
         end
         checks++;
         if (mem_valid) begin
            found = 1'b1;
            if (mem_beat !== 2'd0 || grant_id !== 4'd3) begin
               failures++;
               $display("FAIL rmid_restart: beat %0d id %0d want 0 3", mem_beat, grant_id);
            end
            checks++;
         end
      end
      if (!found) begin
         failures++;
         $display("FAIL rmid_restart_timeout: got no beat want beat 0");
      end
      checks++;
   endtask

   task automatic test_wbprio();
      int seq[$];
      int exp_seq[2];
      bit prev_busy = 1'b0;
      if (WBPRIO) exp_seq = '{9, 1};
      else exp_seq = '{1, 9};
      reset_dut();
      req_wb[1] = 1'b0;
      req_wb[9] = 1'b1;
      req[1] = 1'b1;
      req[9] = 1'b1;
      for (int k = 0; k < 60 && seq.size() < 2; k++) begin
         tick();
         if ((obs & mask) !== (expv & mask)) begin
            failures++;
            $display("FAIL wbprio_cycle%0d: got %h want %h", k, obs & mask, expv & mask);
         end
         checks++;
         if (busy && !prev_busy) seq.push_back(int'(grant_id));
         prev_busy = busy;
      end
      for (int i = 0; i < 2; i++) begin
         if (i >= seq.size() || seq[i] != exp_seq[i]) begin
            failures++;
            $display("FAIL wbprio_order[%0d]: got %0d want %0d", i, (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
         end
         checks++;
      end
   endtask

   task automatic test_random();
      int nsync = 0;
      reset_dut();
      for (int k = 0; k < 3000; k++) begin
         tick();
         if ((obs & mask) !== (expv & mask)) begin
            failures++;
            $display("FAIL rand_cycle%0d: got %h want %h", k, obs & mask, expv & mask);
         end
         checks++;
         if (sync != '0) nsync++;
         mem_ready = ($urandom_range(3) != 0);
         for (int b = 0; b < NB; b++) begin
            if (!req[b] && !exp_sync[b] && $urandom_range(7) == 0) begin
               req[b] = 1'b1;
               req_wb[b] = 1'($urandom_range(1));
               req_row[b*AW +: AW] = AW'($urandom);
               req_crow[b*CW +: CW] = CW'($urandom);
            end else if (req[b] && $urandom_range(15) == 0) begin
               req_wb[b] = 1'($urandom_range(1));
               req_row[b*AW +: AW] = AW'($urandom);
               req_crow[b*CW +: CW] = CW'($urandom);
            end
         end
         if (m_busy && $urandom_range(31) == 0) req[m_bank] = 1'b0;
      end
      if (nsync < 50) begin
         failures++;
         $display("FAIL rand_progress: got %0d syncs want at least 50", nsync);
      end
      checks++;
   endtask

   initial begin
      reset = 1'b1;
      req = '0;
      req_wb = '0;
      req_row = '0;
      req_crow = '0;
      mem_ready = 1'b1;
      test_reset();
      test_single();
      test_backpressure();
      test_rr();
      test_wrap();
      test_reset_mid();
      test_wbprio();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
